mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative multiply/divide unit in the execute stage, beside the combinational ALU and fed by the same register-file operands (a = rs, b = rt).
Implements MULT, MULTU, DIV, DIVU into the architectural HI/LO registers, plus the MTHI/MTLO writes.
Asserts busy so the control path stalls while an operation runs; MFHI/MFLO read the hi/lo outputs directly.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk     input   1      rising-edge clock, the only clock
reset   input   1      synchronous, active-high reset
start   input   1      launch the operation selected by op; sampled only when busy=0
op      input   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a       input   32     rs operand: multiplicand / dividend; also MTHI/MTLO data
b       input   32     rt operand: multiplier / divisor
hi_we   input   1      MTHI: HI <= a
lo_we   input   1      MTLO: LO <= a
hi      output  32     HI register
lo      output  32     LO register
busy    output  1      operation in progress
done    output  1      one-cycle pulse when HI/LO take a new result

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, done=0; state=IDLE; counter=0.
- Reset while busy aborts the operation on that edge. HI/LO are cleared, not written with a partial result.
- FSM states: IDLE, ITER, FIX.
- IDLE, start=1 at edge E0:
  - latch |a|, |b| (unsigned ops take a and b as-is), the op, and the sign bits;
  - counter=0; go to ITER; busy=1 from E0.
- ITER: one iteration per edge; 32 edges E1..E32; counter runs 0..31; go to FIX when counter=31.
  - Multiply: shift-add. 64-bit accumulator {P_hi, P_lo}, with the multiplier initially in P_lo. Add the multiplicand into P_hi when P_lo[0]=1, then shift right one with the adder carry.
  - Divide: restoring. Shift {R, Q} left one, trial-subtract the divisor from R; if non-negative, keep the difference and set Q[0]=1.
- FIX (edge E33):
  - apply sign correction: two's-complement negate on the 32-bit halves / 64-bit product;
  - write HI/LO; busy=0 and done=1 after E33;
  - return to IDLE; done drops on the next edge.
  - Results are visible 33 cycles after the start edge.
- Signed rules:
  - product negated if a[31]^b[31];
  - quotient negated if a[31]^b[31];
  - remainder takes the sign of the dividend;
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (falls out of the magnitude path).
- Results:
  - MULT/MULTU: HI = upper 32 bits of the 64-bit product, LO = lower 32 bits.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero (b=0, either signed or unsigned): LO=0xFFFFFFFF, HI=a (original, unmodified). Same 33-cycle latency; no exception.
- start while busy=1: ignored, with no queueing. hi_we/lo_we while busy=1: ignored.
- Same edge, IDLE: start has priority over hi_we/lo_we, which are dropped. hi_we and lo_we together write a to both registers.
- hi_we/lo_we in IDLE: write at the edge; done is not pulsed.
- hi/lo outputs come straight from the registers; there is no combinational path from a/b.

Decomposition:
- Shared package mdu_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state enum IDLE/ITER/FIX;
  - DIV0_LO constant 0xFFFFFFFF.
- The op encodings are also used by the control decoder.
- No sub-module needed. The datapath shares one 33-bit adder/subtractor between the multiply and divide paths inside mul_div_unit.

Test Plan:
1. Reset held 2 cycles, then released -> hi=0, lo=0, busy=0, done=0. MTLO with a=0x12345678, lo_we=1 -> lo=0x12345678 next cycle, done stays 0.
2. MULT a=0xFFFFFFFD (-3), b=7 -> busy for 33 cycles, done pulses for exactly 1 cycle, hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
4. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7, latency 33.
5. MULTU 3*5 started, then start with op=DIV and hi_we asserted at cycle 10 while busy -> both ignored; final hi=0, lo=15 at cycle 33.
6. DIV started, reset asserted at cycle 10 -> busy=0, hi=lo=0 next cycle, no done pulse. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the control decoder.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO: shift-add multiply, restoring divide,
// one shared adder, magnitude datapath with sign fix-up in the final cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW   = $clog2(WIDTH);
  localparam int unsigned AW   = WIDTH + 2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic             neg_q;      // negate product / quotient
  logic             neg_rem_q;  // negate remainder
  logic [WIDTH-1:0] opnd_q;     // |multiplicand| or |divisor|
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             signed_op;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic             add_cin;
  logic [AW-1:0]    add_res;
  logic             no_borrow;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  // Operand magnitudes; unsigned ops pass straight through.
  always_comb begin
    signed_op = ~op[0];
    abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;
  end

  // Shared adder: P_hi + multiplicand, or {R,Q msb} - divisor via carry-out.
  always_comb begin
    add_a   = {1'b0, acc_hi};
    add_b   = {1'b0, opnd_q};
    add_cin = 1'b0;
    if (op_q[1]) begin
      add_a   = {acc_hi, acc_lo[WIDTH-1]};
      add_b   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end
    add_res   = {1'b0, add_a} + {1'b0, add_b} + AW'(add_cin);
    no_borrow = add_res[AW-1];
  end

  // Sign correction and divide-by-zero result selection.
  always_comb begin
    prod = {acc_hi, acc_lo};
    if (neg_q) prod = -prod;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (opnd_q == '0) begin
        fix_hi = a_q;
        fix_lo = WIDTH'(DIV0_LO);
      end else begin
        fix_hi = neg_rem_q ? -acc_hi : acc_hi;
        fix_lo = neg_q ? -acc_lo : acc_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_q      <= OP_MULT;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      a_q       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            neg_q     <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= signed_op & a[WIDTH-1];
            a_q       <= a;
            acc_hi    <= '0;
            opnd_q    <= op[1] ? abs_b : abs_a;
            acc_lo    <= op[1] ? abs_a : abs_b;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ITER;
          end else begin
            if (hi_we) hi <= a;
            if (lo_we) lo <= a;
          end
        end
        ITER: begin
          if (op_q[1]) begin
            acc_hi <= no_borrow ? add_res[WIDTH-1:0] : {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            acc_lo <= {acc_lo[WIDTH-2:0], no_borrow};
          end else if (acc_lo[0]) begin
            {acc_hi, acc_lo} <= {add_res[WIDTH:0], acc_lo[WIDTH-1:1]};
          end else begin
            {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model checked every cycle plus directed literals.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural result {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model_result(input logic [1:0] f_op, input logic [31:0] fa,
                                               input logic [31:0] fb);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [31:0]     q;
    logic [31:0]     r;
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    ua = {32'd0, fa};
    ub = {32'd0, fb};
    case (f_op)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      default: begin
        if (fb == 32'd0) return {fa, 32'hFFFF_FFFF};
        if (f_op == 2'b10) begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
        end else begin
          q = 32'(ua / ub);
          r = 32'(ua % ub);
        end
        return {r, q};
      end
    endcase
  endfunction

  // Cycle model: busy for 33 cycles after a start, then result and one-cycle done.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_busy, m_done;
  int          m_left;

  always @(posedge clk) begin
    if (reset) begin
      m_hi <= 0; m_lo <= 0; m_busy <= 0; m_done <= 0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= p_hi;
          m_lo   <= p_lo;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        {p_hi, p_lo} <= model_result(op, a, b);
        m_busy <= 1'b1;
        m_left <= 33;
      end else begin
        if (hi_we) m_hi <= a;
        if (lo_we) m_lo <= a;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_hi", 64'(hi), 64'(m_hi));
      check("cyc_lo", 64'(lo), 64'(m_lo));
      check("cyc_busy", 64'(busy), 64'(m_busy));
      check("cyc_done", 64'(done), 64'(m_done));
    end
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done (bounded); returns cycles counted from the negedge after the start edge.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] e_hi, input logic [31:0] e_lo);
    int n;
    check({name, "_model"}, model_result(o, x, y), {e_hi, e_lo});
    launch(o, x, y);
    wait_done(n);
    check({name, "_latency"}, 64'(n), 64'd33);
    check({name, "_hi"}, 64'(hi), 64'(e_hi));
    check({name, "_lo"}, 64'(lo), 64'(e_lo));
    @(negedge clk);
    check({name, "_done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // MTLO / MTHI
    a = 32'h1234_5678; lo_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h1234_5678);
    check("mtlo_done", 64'(done), 64'd0);
    a = 32'hCAFE_F00D; hi_we = 1'b1; lo_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both_hi", 64'(hi), 64'hCAFE_F00D);
    check("mt_both_lo", 64'(lo), 64'hCAFE_F00D);

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_pos", 2'b00, 32'd12345, 32'd678, 32'd0, 32'd8369910);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_negdiv", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_zero", 2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // start/hi_we in the same IDLE edge: start wins, hi_we dropped.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5; hi_we = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    // Start and MTHI while busy are both ignored.
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'h1111_1111; b = 32'd3; hi_we = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_done(n);
    check("busy_ign_done_seen", 64'(done), 64'd1);
    check("busy_ign_hi", 64'(hi), 64'd0);
    check("busy_ign_lo", 64'(lo), 64'd15);
    @(negedge clk);
    check("busy_ign_idle", 64'(busy), 64'd0);

    // Reset in the middle of a divide.
    launch(2'b10, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    repeat (40) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    run_op("after_abort", 2'b10, 32'd1000, 32'd3, 32'd1, 32'd333);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
